// File: rtl/ipf_stream.sv
// 3x3 feature/weight feeder: NPE cubes with column wrap, kernel sets rotated every NROWS beats.
// res is combinational (0 cycles), valid 1 cycle after START; res_ready=0 freezes rows/beat/ksel.
module ipf_stream #(
  parameter int DATA_W  = 8,
  parameter int ROW_PIX = 8,
  parameter int NROWS   = 8,
  parameter int NPE     = 8,
  parameter int WSETS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    ctrl,
  input  logic [ROW_PIX*DATA_W-1:0]     i_data,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [ROW_PIX*DATA_W-1:0]     w_data,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [NPE*9*2*DATA_W-1:0]     res,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(WSETS)-1:0]      ksel,
  output logic                          finish
);
  localparam int BUS_W  = ROW_PIX * DATA_W;
  localparam int WBITS  = WSETS * 9 * DATA_W;
  localparam int WWORDS = (WBITS + BUS_W - 1) / BUS_W;
  localparam int KW     = $clog2(WSETS);
  localparam int PW     = $clog2(WWORDS + 1);
  localparam int BW     = $clog2(NROWS);
  localparam int CW     = $clog2(NROWS + 1);
  localparam int PRW    = 2 * DATA_W;

  typedef enum logic [1:0] {ST_WAIT, ST_COMPUTE, ST_FINISH} state_t;

  state_t           state, state_nxt;
  logic [BUS_W-1:0] row [NROWS];
  logic [WBITS-1:0] wbuf;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    rows_cnt;
  logic [BW-1:0]    beat;
  logic [9*DATA_W-1:0] kern;
  logic row_acc, w_acc, fire, loaded, hold_exit;

  assign i_ready   = (state == ST_WAIT);
  assign w_ready   = (state == ST_WAIT) && (wptr < PW'(WWORDS));
  assign res_valid = (state == ST_COMPUTE);
  assign finish    = (state == ST_FINISH);
  assign row_acc   = i_valid & i_ready;
  assign w_acc     = w_valid & w_ready;
  assign fire      = res_valid & res_ready;
  assign loaded    = (rows_cnt >= CW'(3)) && (wptr == PW'(WWORDS));
  assign hold_exit = (state == ST_COMPUTE) && (state_nxt == ST_WAIT);

  // END outranks START/HOLD; START needs three rows and a full weight bank
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: begin
        if (ctrl == 2'd0)                state_nxt = ST_FINISH;
        else if (ctrl == 2'd1 && loaded) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (ctrl == 2'd0)      state_nxt = ST_FINISH;
        else if (ctrl == 2'd2) state_nxt = ST_WAIT;
      end
      ST_FINISH: state_nxt = ST_FINISH;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NROWS; k++) row[k] <= '0;
      wbuf     <= '0;
      wptr     <= '0;
      rows_cnt <= '0;
      beat     <= '0;
      ksel     <= '0;
    end else begin
      if (row_acc) begin
        for (int k = 0; k < NROWS-1; k++) row[k] <= row[k+1];
        row[NROWS-1] <= i_data;
        if (rows_cnt != CW'(NROWS)) rows_cnt <= rows_cnt + CW'(1);
      end else if (fire) begin
        for (int k = 0; k < NROWS-1; k++) row[k] <= row[k+1];
        row[NROWS-1] <= row[0];
      end
      // tail of the last word past the bank is dropped
      if (w_acc) begin
        for (int b = 0; b < BUS_W; b++)
          if (int'(wptr) * BUS_W + b < WBITS) wbuf[int'(wptr) * BUS_W + b] <= w_data[b];
        wptr <= wptr + PW'(1);
      end
      if (fire) begin
        if (beat == BW'(NROWS-1)) begin
          beat <= '0;
          ksel <= (ksel == KW'(WSETS-1)) ? '0 : ksel + KW'(1);
        end else begin
          beat <= beat + BW'(1);
        end
      end
      if (hold_exit) begin
        beat <= '0;
        ksel <= '0;
        wptr <= '0;
      end
    end
  end

  assign kern = wbuf[int'(ksel) * 9 * DATA_W +: 9 * DATA_W];

  always_comb begin
    res = '0;
    for (int p = 0; p < NPE; p++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          res[(p*9 + r*3 + c)*PRW +: PRW] =
            PRW'(kern[(r*3 + c)*DATA_W +: DATA_W]) *
            PRW'(row[r][((p + c) % ROW_PIX)*DATA_W +: DATA_W]);
  end
endmodule
